// File: rtl/axi_pkg.sv
// Shared AXI encodings and the write-controller state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Normal non-cacheable bufferable.
  localparam logic [3:0] AXI_CACHE_NC_BUF = 4'b0011;

  localparam int AXI_PAGE_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Next burst length: smallest of beats remaining, MAX_BURST and the beats
// left before the next 4 KB page. Pure combinational.
module axi_burst_len_calc
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 16
) (
  input  logic [11:0] page_off,
  input  logic [15:0] remaining,
  output logic [8:0]  burst_len
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH/8);

  logic [12:0] page_bytes;
  logic [12:0] page_beats;

  // Clamp the length against the cap, the page boundary and what is left.
  always_comb begin
    page_bytes = 13'(AXI_PAGE_BYTES) - {1'b0, page_off};
    page_beats = page_bytes >> BEAT_SHIFT;
    burst_len  = 9'(MAX_BURST);
    if (page_beats < {4'd0, burst_len}) burst_len = page_beats[8:0];
    if (remaining < {7'd0, burst_len}) burst_len = remaining[8:0];
  end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// AXI write burst controller: splits a beat-count command into INCR bursts
// that never cross a 4 KB page, one burst outstanding at a time.
// Optional feature macro AXI_WR_IRQ_EN: sticky completion interrupt on o_irq.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// AW    | presenting the current burst address until accepted
// W     | passing source data straight through to the W channel
// B     | waiting for the write response of the current burst
// DONE  | completion cycle, then back to IDLE
module axi_wr_burst_ctrl
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 16,
  parameter int AXI_ID     = 0
) (
  input  logic                    i_aclk,
  input  logic                    i_aresetn,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [15:0]             i_cmd_beats,
  input  logic                    i_wd_valid,
  output logic                    o_wd_ready,
  input  logic [DATA_WIDTH-1:0]   i_wd_data,
  output logic                    o_done,
  output logic                    o_err,
  output logic                    o_irq,
  output logic [ID_WIDTH-1:0]     o_awid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic                    o_awlock,
  output logic [3:0]              o_awcache,
  output logic [2:0]              o_awprot,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ID_WIDTH-1:0]     o_wid,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [ID_WIDTH-1:0]     i_bid,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH/8);

  wr_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           remaining;
  logic [8:0]            beat_left;
  logic [8:0]            burst_len;
  logic                  err_flag;
  logic                  done_q;
  logic                  err_q;
  logic                  cmd_fire;
  logic                  w_fire;
  logic                  b_bad;
  logic                  last_burst;

  // Length is derived from registered addr/remaining, so AW fields hold
  // steady for the whole AW phase.
  axi_burst_len_calc #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .page_off (addr_q[11:0]),
    .remaining(remaining),
    .burst_len(burst_len)
  );

  assign cmd_fire   = (state == ST_IDLE) && i_cmd_valid;
  assign w_fire     = (state == ST_W) && i_wd_valid && i_wready;
  assign b_bad      = (i_bresp != AXI_RESP_OKAY) || (i_bid != ID_WIDTH'(AXI_ID));
  assign last_burst = (remaining == {7'd0, burst_len});

  assign o_awid    = ID_WIDTH'(AXI_ID);
  assign o_wid     = ID_WIDTH'(AXI_ID);
  assign o_awaddr  = addr_q;
  assign o_awlen   = 8'(burst_len - 9'd1);
  assign o_awsize  = 3'(BEAT_SHIFT);
  assign o_awburst = AXI_BURST_INCR;
  assign o_awlock  = 1'b0;
  assign o_awcache = AXI_CACHE_NC_BUF;
  assign o_awprot  = 3'b000;
  assign o_wstrb   = '1;
  assign o_wdata   = i_wd_data;
  assign o_done    = done_q;
  assign o_err     = err_q;

  // State register.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode and channel handshake outputs.
  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_wd_ready  = 1'b0;
    o_wlast     = 1'b0;
    o_bready    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low while reset is asserted so no command is seen as taken.
        o_cmd_ready = i_aresetn;
        if (i_cmd_valid) state_nxt = (i_cmd_beats == 16'd0) ? ST_DONE : ST_AW;
      end
      ST_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) state_nxt = ST_W;
      end
      ST_W: begin
        o_wvalid   = i_wd_valid;
        o_wd_ready = i_wready;
        o_wlast    = (beat_left == 9'd1);
        if (w_fire && (beat_left == 9'd1)) state_nxt = ST_B;
      end
      ST_B: begin
        o_bready = 1'b1;
        if (i_bvalid) state_nxt = (b_bad || last_burst) ? ST_DONE : ST_AW;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/remaining bookkeeping, beat down-counter, error and done flags.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      addr_q    <= '0;
      remaining <= '0;
      beat_left <= '0;
      err_flag  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      err_q  <= (state == ST_DONE) && err_flag;
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            addr_q    <= i_cmd_addr;
            remaining <= i_cmd_beats;
            err_flag  <= 1'b0;
          end
        end
        ST_AW: if (i_awready) beat_left <= burst_len;
        ST_W:  if (w_fire) beat_left <= beat_left - 9'd1;
        ST_B: begin
          if (i_bvalid) begin
            if (b_bad) begin
              err_flag <= 1'b1;
            end else begin
              addr_q    <= addr_q + (ADDR_WIDTH'(burst_len) << BEAT_SHIFT);
              remaining <= remaining - {7'd0, burst_len};
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_WR_IRQ_EN
  logic irq_q;

  // Sticky interrupt: raised at completion, dropped when the next command is taken.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn)              irq_q <= 1'b0;
    else if (state == ST_DONE)   irq_q <= 1'b1;
    else if (cmd_fire)           irq_q <= 1'b0;
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
`timescale 1ns/1ps
module tb_axi_wr_burst_ctrl;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 31;
  localparam int DATA_WIDTH = 128;
  localparam int MAX_BURST  = 16;
  localparam int AXI_ID     = 0;

`ifdef AXI_WR_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic                    i_aclk = 1'b0;
  logic                    i_aresetn = 1'b0;
  logic                    i_cmd_valid = 1'b0;
  logic                    o_cmd_ready;
  logic [ADDR_WIDTH-1:0]   i_cmd_addr = '0;
  logic [15:0]             i_cmd_beats = '0;
  logic                    i_wd_valid = 1'b0;
  logic                    o_wd_ready;
  logic [DATA_WIDTH-1:0]   i_wd_data = '0;
  logic                    o_done, o_err, o_irq;
  logic [ID_WIDTH-1:0]     o_awid;
  logic [ADDR_WIDTH-1:0]   o_awaddr;
  logic [7:0]              o_awlen;
  logic [2:0]              o_awsize;
  logic [1:0]              o_awburst;
  logic                    o_awlock;
  logic [3:0]              o_awcache;
  logic [2:0]              o_awprot;
  logic                    o_awvalid;
  logic                    i_awready = 1'b0;
  logic [ID_WIDTH-1:0]     o_wid;
  logic [DATA_WIDTH-1:0]   o_wdata;
  logic [DATA_WIDTH/8-1:0] o_wstrb;
  logic                    o_wlast, o_wvalid;
  logic                    i_wready = 1'b0;
  logic [ID_WIDTH-1:0]     i_bid = '0;
  logic [1:0]              i_bresp = '0;
  logic                    i_bvalid = 1'b0;
  logic                    o_bready;

  axi_wr_burst_ctrl #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST(MAX_BURST), .AXI_ID(AXI_ID)
  ) dut (
    .i_aclk(i_aclk), .i_aresetn(i_aresetn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_beats(i_cmd_beats),
    .i_wd_valid(i_wd_valid), .o_wd_ready(o_wd_ready), .i_wd_data(i_wd_data),
    .o_done(o_done), .o_err(o_err), .o_irq(o_irq),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache),
    .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  always #5 i_aclk = ~i_aclk;

  int checks = 0;
  int errors = 0;

  int                    cyc = 0;
  logic [ADDR_WIDTH-1:0] aw_addr_q[$];
  logic [7:0]            aw_len_q[$];
  logic [DATA_WIDTH-1:0] w_data_q[$];
  int                    w_last_idx[$];
  int                    done_count = 0;
  logic                  done_err = 1'b0;
  int                    done_cyc = 0;
  int                    accept_cyc = 0;
  int                    busy_cycles = 0;
  int                    b_count = 0;
  int                    stab_err = 0;
  logic                  wd_taken = 1'b0;
  logic                  b_taken = 1'b0;
  logic                  aw_pend = 1'b0;
  logic [ADDR_WIDTH-1:0] aw_addr_prev = '0;
  logic [7:0]            aw_len_prev = '0;
  logic                  w_pend = 1'b0;
  logic [DATA_WIDTH-1:0] w_data_prev = '0;
  logic                  w_last_prev = 1'b0;

  logic                  src_en = 1'b1;
  logic                  stall = 1'b0;
  int                    err_burst = -1;
  logic [ID_WIDTH-1:0]   bid_val = '0;
  logic [31:0]           wd_seq = '0;

  // Bus monitor: records handshakes and checks hold-while-valid on AW and W.
  always @(posedge i_aclk) begin
    cyc++;
    wd_taken = 1'b0;
    b_taken  = 1'b0;
    if (i_aresetn) begin
      if (aw_pend && (!o_awvalid || o_awaddr !== aw_addr_prev || o_awlen !== aw_len_prev)) stab_err++;
      if (w_pend && (!o_wvalid || o_wdata !== w_data_prev || o_wlast !== w_last_prev)) stab_err++;
      aw_pend      = o_awvalid && !i_awready;
      aw_addr_prev = o_awaddr;
      aw_len_prev  = o_awlen;
      w_pend       = o_wvalid && !i_wready;
      w_data_prev  = o_wdata;
      w_last_prev  = o_wlast;
      if (o_awvalid && i_awready) begin
        aw_addr_q.push_back(o_awaddr);
        aw_len_q.push_back(o_awlen);
      end
      if (o_wvalid && i_wready) begin
        w_data_q.push_back(o_wdata);
        if (o_wlast) w_last_idx.push_back(w_data_q.size());
        wd_taken = 1'b1;
      end
      if (i_bvalid && o_bready) begin
        b_taken = 1'b1;
        b_count++;
      end
      if (i_cmd_valid && o_cmd_ready) accept_cyc = cyc;
      if (o_awvalid || o_wvalid || o_bready) busy_cycles++;
      if (o_done) begin
        done_count++;
        done_cyc = cyc;
        done_err = o_err;
      end
    end else begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end
  end

  // Source stream, AW/W slave readiness and B responder, updated on the falling edge.
  initial begin
    forever begin
      @(negedge i_aclk);
      if (wd_taken) begin
        wd_seq     = wd_seq + 32'd1;
        i_wd_valid = 1'b0;
      end
      if (!i_wd_valid) i_wd_valid = src_en && (!stall || ($urandom_range(0, 1) == 1));
      if (!src_en) i_wd_valid = 1'b0;
      i_wd_data = {4{wd_seq}};
      i_wready  = !stall || ($urandom_range(0, 1) == 1);
      i_awready = !stall || ($urandom_range(0, 2) != 0);
      if (b_taken || !i_aresetn) i_bvalid = 1'b0;
      if (!i_bvalid && o_bready && (!stall || ($urandom_range(0, 1) == 1))) begin
        i_bvalid = 1'b1;
        i_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
        i_bid    = bid_val;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic run_cmd(input logic [ADDR_WIDTH-1:0] a, input logic [15:0] b,
                         output bit ok, output logic irq_after_accept);
    int d0;
    d0 = done_count;
    @(negedge i_aclk);
    i_cmd_addr  = a;
    i_cmd_beats = b;
    i_cmd_valid = 1'b1;
    @(negedge i_aclk);
    i_cmd_valid = 1'b0;
    irq_after_accept = o_irq;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_count != d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_aclk);
    end
    repeat (3) @(negedge i_aclk);
  endtask

  task automatic test_reset();
    i_aresetn = 1'b0;
    repeat (3) @(negedge i_aclk);
    checks++;
    if ({o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_wd_ready, o_done, o_err, o_irq} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_wd_ready, o_done, o_err, o_irq});
    end
    i_aresetn = 1'b1;
    @(negedge i_aclk);
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b want 1", o_cmd_ready);
    end
    checks++;
    if ({o_awsize, o_awburst, o_awlock, o_awcache, o_awprot} !== {3'd4, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
      errors++;
      $display("FAIL fixed_aw_fields got %b want %b", {o_awsize, o_awburst, o_awlock, o_awcache, o_awprot},
               {3'd4, 2'b01, 1'b0, 4'b0011, 3'b000});
    end
    checks++;
    if (o_wstrb !== 16'hFFFF || o_awid !== 4'd0 || o_wid !== 4'd0) begin
      errors++;
      $display("FAIL fixed_ids_strb got strb=%h awid=%0d wid=%0d want ffff 0 0", o_wstrb, o_awid, o_wid);
    end
  endtask

  task automatic test_single_burst();
    int aw0, w0, l0, bad;
    bit ok;
    logic irq_a;
    aw0 = aw_addr_q.size(); w0 = w_data_q.size(); l0 = w_last_idx.size();
    run_cmd(31'h0000_1000, 16'd16, ok, irq_a);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout got none want done"); end
    checks++;
    if (aw_addr_q.size() - aw0 != 1) begin
      errors++; $display("FAIL single_aw_count got %0d want 1", aw_addr_q.size() - aw0);
    end else begin
      checks++;
      if (aw_addr_q[aw0] !== 31'h1000 || aw_len_q[aw0] !== 8'd15) begin
        errors++; $display("FAIL single_aw got addr=%h len=%0d want 1000 15", aw_addr_q[aw0], aw_len_q[aw0]);
      end
    end
    checks++;
    if (w_data_q.size() - w0 != 16) begin
      errors++; $display("FAIL single_w_count got %0d want 16", w_data_q.size() - w0);
    end
    checks++;
    if (w_last_idx.size() - l0 != 1 || w_last_idx[$] != w0 + 16) begin
      errors++; $display("FAIL single_wlast got n=%0d idx=%0d want 1 %0d", w_last_idx.size() - l0, w_last_idx[$], w0 + 16);
    end
    bad = -1;
    for (int i = 0; i < w_data_q.size(); i++) if (bad < 0 && w_data_q[i] !== {4{32'(i)}}) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL single_data_order got bad beat %0d want none", bad); end
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", done_err); end
    checks++;
    if (o_irq !== IRQ_EXP) begin errors++; $display("FAIL single_irq got %b want %b", o_irq, IRQ_EXP); end
  endtask

  task automatic test_4k_split();
    logic [ADDR_WIDTH-1:0] ea[3];
    logic [7:0]            el[3];
    int                    eli[3];
    int aw0, w0, l0, bad;
    bit ok;
    logic irq_a;
    ea = '{31'h1F80, 31'h2000, 31'h2100};
    el = '{8'd7, 8'd15, 8'd15};
    aw0 = aw_addr_q.size(); w0 = w_data_q.size(); l0 = w_last_idx.size();
    eli = '{w0 + 8, w0 + 24, w0 + 40};
    run_cmd(31'h0000_1F80, 16'd40, ok, irq_a);
    checks++;
    if (!ok) begin errors++; $display("FAIL split_done_timeout got none want done"); end
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL split_irq_clear got %b want 0", irq_a); end
    checks++;
    if (aw_addr_q.size() - aw0 != 3 || w_last_idx.size() - l0 != 3) begin
      errors++; $display("FAIL split_burst_count got aw=%0d last=%0d want 3 3", aw_addr_q.size() - aw0, w_last_idx.size() - l0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (aw_addr_q[aw0 + k] !== ea[k] || aw_len_q[aw0 + k] !== el[k] || w_last_idx[l0 + k] != eli[k]) begin
          errors++;
          $display("FAIL split_burst%0d got addr=%h len=%0d last=%0d want %h %0d %0d", k,
                   aw_addr_q[aw0 + k], aw_len_q[aw0 + k], w_last_idx[l0 + k], ea[k], el[k], eli[k]);
        end
      end
    end
    bad = -1;
    for (int i = 0; i < w_data_q.size(); i++) if (bad < 0 && w_data_q[i] !== {4{32'(i)}}) bad = i;
    checks++;
    if (bad >= 0 || w_data_q.size() - w0 != 40) begin
      errors++; $display("FAIL split_data got bad=%0d n=%0d want -1 40", bad, w_data_q.size() - w0);
    end
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL split_err got %b want 0", done_err); end
  endtask

  task automatic test_zero_beats();
    int bc0;
    bit ok;
    logic irq_a;
    bc0 = busy_cycles;
    run_cmd(31'h0000_0500, 16'd0, ok, irq_a);
    checks++;
    if (!ok || done_cyc - accept_cyc != 2) begin
      errors++; $display("FAIL zero_done_latency got ok=%0d lat=%0d want 1 2", ok, done_cyc - accept_cyc);
    end
    checks++;
    if (busy_cycles != bc0) begin
      errors++; $display("FAIL zero_no_traffic got %0d busy cycles want 0", busy_cycles - bc0);
    end
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL zero_err got %b want 0", done_err); end
  endtask

  task automatic test_slverr();
    int aw0, w0;
    bit ok;
    logic irq_a;
    aw0 = aw_addr_q.size(); w0 = w_data_q.size();
    err_burst = b_count;
    run_cmd(31'h0000_4000, 16'd32, ok, irq_a);
    err_burst = -1;
    checks++;
    if (!ok || aw_addr_q.size() - aw0 != 1 || w_data_q.size() - w0 != 16) begin
      errors++; $display("FAIL slverr_abort got ok=%0d aw=%0d w=%0d want 1 1 16", ok, aw_addr_q.size() - aw0, w_data_q.size() - w0);
    end
    checks++;
    if (done_err !== 1'b1) begin errors++; $display("FAIL slverr_err got %b want 1", done_err); end
    checks++;
    if (o_irq !== IRQ_EXP) begin errors++; $display("FAIL slverr_irq got %b want %b", o_irq, IRQ_EXP); end

    aw0 = aw_addr_q.size();
    bid_val = 4'd1;
    run_cmd(31'h0000_8000, 16'd20, ok, irq_a);
    bid_val = 4'd0;
    checks++;
    if (!ok || aw_addr_q.size() - aw0 != 1 || done_err !== 1'b1) begin
      errors++; $display("FAIL bad_bid got ok=%0d aw=%0d err=%b want 1 1 1", ok, aw_addr_q.size() - aw0, done_err);
    end
  endtask

  task automatic test_back_to_back();
    int aw0;
    bit ok;
    logic irq_a;
    aw0 = aw_addr_q.size();
    run_cmd(31'h0000_0000, 16'd5, ok, irq_a);
    checks++;
    if (!ok || done_err !== 1'b0) begin
      errors++; $display("FAIL b2b_err_cleared got ok=%0d err=%b want 1 0", ok, done_err);
    end
    checks++;
    if (aw_addr_q.size() - aw0 != 1 || aw_len_q[$] !== 8'd4) begin
      errors++; $display("FAIL b2b_aw got n=%0d len=%0d want 1 4", aw_addr_q.size() - aw0, aw_len_q[$]);
    end
    aw0 = aw_addr_q.size();
    run_cmd(31'h7FFF_FFE0, 16'd4, ok, irq_a);
    checks++;
    if (!ok || aw_addr_q.size() - aw0 != 2) begin
      errors++; $display("FAIL wrap_count got ok=%0d aw=%0d want 1 2", ok, aw_addr_q.size() - aw0);
    end else begin
      checks++;
      if (aw_addr_q[aw0] !== 31'h7FFF_FFE0 || aw_len_q[aw0] !== 8'd1 ||
          aw_addr_q[aw0 + 1] !== 31'h0 || aw_len_q[aw0 + 1] !== 8'd1) begin
        errors++;
        $display("FAIL wrap_bursts got %h/%0d %h/%0d want 7fffffe0/1 0/1",
                 aw_addr_q[aw0], aw_len_q[aw0], aw_addr_q[aw0 + 1], aw_len_q[aw0 + 1]);
      end
    end
  endtask

  task automatic test_stalls();
    logic [ADDR_WIDTH-1:0] ea[3];
    logic [7:0]            el[3];
    int                    eli[3];
    int aw0, w0, l0, s0, bad;
    bit ok;
    logic irq_a;
    ea = '{31'h3000, 31'h3100, 31'h3200};
    el = '{8'd15, 8'd15, 8'd4};
    aw0 = aw_addr_q.size(); w0 = w_data_q.size(); l0 = w_last_idx.size(); s0 = stab_err;
    eli = '{w0 + 16, w0 + 32, w0 + 37};
    stall = 1'b1;
    run_cmd(31'h0000_3000, 16'd37, ok, irq_a);
    stall = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done_timeout got none want done"); end
    checks++;
    if (stab_err != s0) begin errors++; $display("FAIL stall_stability got %0d violations want 0", stab_err - s0); end
    checks++;
    if (aw_addr_q.size() - aw0 != 3 || w_last_idx.size() - l0 != 3) begin
      errors++; $display("FAIL stall_bursts got aw=%0d last=%0d want 3 3", aw_addr_q.size() - aw0, w_last_idx.size() - l0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (aw_addr_q[aw0 + k] !== ea[k] || aw_len_q[aw0 + k] !== el[k] || w_last_idx[l0 + k] != eli[k]) begin
          errors++;
          $display("FAIL stall_burst%0d got addr=%h len=%0d last=%0d want %h %0d %0d", k,
                   aw_addr_q[aw0 + k], aw_len_q[aw0 + k], w_last_idx[l0 + k], ea[k], el[k], eli[k]);
        end
      end
    end
    bad = -1;
    for (int i = 0; i < w_data_q.size(); i++) if (bad < 0 && w_data_q[i] !== {4{32'(i)}}) bad = i;
    checks++;
    if (bad >= 0 || w_data_q.size() - w0 != 37) begin
      errors++; $display("FAIL stall_data got bad=%0d n=%0d want -1 37", bad, w_data_q.size() - w0);
    end
  endtask

  task automatic test_reset_mid_w();
    int d0, aw0;
    bit in_w, ok;
    logic irq_a;
    src_en = 1'b0;
    d0 = done_count;
    @(negedge i_aclk);
    i_cmd_addr  = 31'h0000_1000;
    i_cmd_beats = 16'd16;
    i_cmd_valid = 1'b1;
    @(negedge i_aclk);
    i_cmd_valid = 1'b0;
    in_w = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_wd_ready) begin
        in_w = 1'b1;
        break;
      end
      @(negedge i_aclk);
    end
    checks++;
    if (!in_w) begin errors++; $display("FAIL rstw_reach_w got no W phase want W"); end
    i_aresetn = 1'b0;
    @(negedge i_aclk);
    checks++;
    if ({o_awvalid, o_wvalid, o_bready, o_wd_ready, o_wlast, o_done, o_err, o_irq} !== 8'h00) begin
      errors++;
      $display("FAIL rstw_outputs got %b want 00000000",
               {o_awvalid, o_wvalid, o_bready, o_wd_ready, o_wlast, o_done, o_err, o_irq});
    end
    i_aresetn = 1'b1;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rstw_cmd_ready got %b want 1", o_cmd_ready); end
    src_en = 1'b1;
    repeat (20) @(negedge i_aclk);
    checks++;
    if (done_count != d0) begin errors++; $display("FAIL rstw_no_done got %0d pulses want 0", done_count - d0); end
    aw0 = aw_addr_q.size();
    run_cmd(31'h0000_2000, 16'd16, ok, irq_a);
    checks++;
    if (!ok || aw_addr_q.size() - aw0 != 1 || done_err !== 1'b0) begin
      errors++; $display("FAIL rstw_recover got ok=%0d aw=%0d err=%b want 1 1 0", ok, aw_addr_q.size() - aw0, done_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_zero_beats();
    test_slverr();
    test_back_to_back();
    test_stalls();
    test_reset_mid_w();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_ctrl.md
AXI_WR_BURST_CTRL -- requirements
Module: axi_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 31, AXI byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, AXI data width; beat = DATA_WIDTH/8 bytes.
REQ-004 SHALL have parameter MAX_BURST, default 16, max beats per AXI burst (1..256).
REQ-005 SHALL have parameter AXI_ID, default 0, constant value driven on o_awid and o_wid.
REQ-006 i_aclk  in  1  sole clock; all logic on its rising edge.
REQ-007 i_aresetn  in  1  reset, synchronous, active-low.
REQ-008 i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake.
REQ-009 i_cmd_addr  in  ADDR_WIDTH  start byte address, beat-aligned.
REQ-010 i_cmd_beats  in  16  total beats; 0 allowed.
REQ-011 i_wd_valid / o_wd_ready / i_wd_data  in/out/in  1/1/DATA_WIDTH  source write-data stream.
REQ-012 o_done / o_err  out  1/1  done one-cycle pulse; err valid with done.
REQ-013 o_irq  out  1  completion interrupt (see Configuration).
REQ-014 o_awid, o_awaddr, o_awlen[7:0], o_awsize[2:0], o_awburst[1:0], o_awlock, o_awcache[3:0], o_awprot[2:0], o_awvalid  out; i_awready  in.
REQ-015 o_wid, o_wdata, o_wstrb[DATA_WIDTH/8-1:0], o_wlast, o_wvalid  out; i_wready  in.
REQ-016 i_bid[ID_WIDTH-1:0], i_bresp[1:0], i_bvalid  in; o_bready  out.

Function
REQ-017 FSM states IDLE, AW, W, B, DONE; one burst outstanding at a time.
REQ-018 IDLE: o_cmd_ready=1; on i_cmd_valid capture addr/beats; beats=0 -> DONE, else -> AW.
REQ-019 Burst length = min(remaining, MAX_BURST, beats to next 4 KB boundary); o_awlen = length-1.
REQ-020 AW: o_awvalid=1 with stable fields until i_awready; then -> W.
REQ-021 Fixed fields: awsize=log2(DATA_WIDTH/8), awburst=INCR, awlock=0, awcache=4'b0011, awprot=0, wstrb all ones.
REQ-022 W: o_wvalid=i_wd_valid, o_wd_ready=i_wready, o_wdata=i_wd_data (combinational pass, zero latency); beat counted on wvalid&wready.
REQ-023 o_wlast=1 exactly on the final beat of each burst; after it -> B.
REQ-024 B: o_bready=1; on i_bvalid, bresp!=OKAY or i_bid!=AXI_ID sets error and -> DONE (remaining bursts aborted).
REQ-025 B with OKAY: address += length*beat bytes, remaining -= length; remaining=0 -> DONE, else -> AW.
REQ-026 DONE: o_done=1 one cycle, o_err=error flag, -> IDLE; error cleared on next command accept.
REQ-027 o_awvalid, o_wvalid, o_bready, o_wd_ready SHALL be 0 outside AW/W/B respectively.
REQ-028 Address arithmetic SHALL be ADDR_WIDTH wide, wrapping modulo 2^ADDR_WIDTH.

Reset
REQ-029 While i_aresetn=0 at a clock edge: FSM->IDLE, counters/error cleared, all valid/ready/done/err/irq outputs 0.
REQ-030 Reset mid-burst SHALL abandon the transfer without completing wlast or waiting for B.

Configuration
REQ-031 Macro AXI_WR_IRQ_EN defined: o_irq registered high from DONE until next command accepted.
REQ-032 AXI_WR_IRQ_EN undefined: o_irq tied 0; no irq register synthesised.

Structure
REQ-033 Shared package axi_pkg SHALL hold AXI burst/resp/cache encodings and the FSM state enum.
REQ-034 Burst-length computation SHALL be a combinational sub-module axi_burst_len_calc.

Verification
REQ-035 addr=0x1000, beats=16, all ready -> one burst awlen=15, wlast on beat 16, done, err=0.
REQ-036 addr=0x1F80, beats=40 -> bursts 8@0x1F80, 16@0x2000, 16@0x2100; no 4 KB crossing.
REQ-037 beats=0 -> o_done two cycles after accept, no awvalid/wvalid.
REQ-038 beats=32, first bresp=SLVERR -> single burst issued, done with err=1.
REQ-039 Random i_wready/i_wd_valid/i_awready stalls -> fields stable while valid, data order preserved.
REQ-040 Reset asserted during W -> next cycle all valids 0, IDLE, cmd_ready=1; irq behaviour per macro.
